// File: rtl/stream_mux_rr.sv
// stream_mux_rr
//   Multiplexes CHANNELS valid/ready input streams onto one registered
//   output stream. The source is either a fixed channel picked by sel
//   (mode = 0) or a round-robin choice among the valid channels (mode = 1).
//   The output register holds one word. A new word can load in the same
//   edge that the previous one leaves, so the block passes one word per
//   cycle.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   mode       0 = fixed select by sel, 1 = round-robin
//   sel        channel index used in fixed mode
//   in_data    flattened channel data; channel i is [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready; at most one bit is high
//   out_data   registered data of the selected channel
//   out_chan   registered index of the channel that supplied out_data
//   out_valid  out_data holds a word
//   out_ready  downstream accepts the word
module stream_mux_rr #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 8,
  localparam int SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic [WIDTH-1:0]    out_data_r;
  logic [SEL_W-1:0]    out_chan_r;
  logic                out_valid_r;
  logic [SEL_W-1:0]    ptr_r;        // last channel granted in round-robin mode

  logic                load_en_s;
  logic                grant_vld_s;
  logic [SEL_W-1:0]    grant_idx_s;
  logic                xfer_in_s;
  logic [WIDTH-1:0]    grant_data_s;
  logic [CHANNELS-1:0] in_ready_s;

  // The output register can take a word when it is empty or is being drained.
  assign load_en_s = !out_valid_r || out_ready;

  // Grant selection: a fixed index or a rotating search that starts after ptr_r.
  always_comb begin
    logic [SEL_W-1:0] idx_v;
    grant_vld_s = 1'b0;
    grant_idx_s = {SEL_W{1'b0}};
    idx_v       = {SEL_W{1'b0}};
    if (mode == 1'b0) begin
      // An index at or above CHANNELS names no channel, so nothing is granted.
      if (int'(sel) < CHANNELS) begin
        grant_vld_s = in_valid[sel];
        grant_idx_s = sel;
      end else begin
        grant_vld_s = 1'b0;
      end
    end else begin
      // The search visits ptr+1 .. ptr and wraps modulo CHANNELS. ptr_r is
      // always below CHANNELS, so no out-of-range index can be produced.
      for (int k = 1; k <= CHANNELS; k++) begin
        idx_v = SEL_W'((int'(ptr_r) + k) % CHANNELS);
        if (!grant_vld_s && in_valid[idx_v]) begin
          grant_vld_s = 1'b1;
          grant_idx_s = idx_v;
        end else begin
          grant_vld_s = grant_vld_s;
        end
      end
    end
  end

  // Data of the granted channel.
  assign grant_data_s = in_data[int'(grant_idx_s)*WIDTH +: WIDTH];

  assign xfer_in_s = grant_vld_s && load_en_s;

  // Ready goes only to the granted channel. It stays low while reset is held
  // because load_en would otherwise be high once the output register is empty.
  always_comb begin
    in_ready_s = {CHANNELS{1'b0}};
    if (rst_n && xfer_in_s) begin
      in_ready_s[grant_idx_s] = 1'b1;
    end else begin
      in_ready_s = {CHANNELS{1'b0}};
    end
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_r  <= {WIDTH{1'b0}};
      out_chan_r  <= {SEL_W{1'b0}};
      out_valid_r <= 1'b0;
      ptr_r       <= SEL_W'(CHANNELS - 1);
    end else if (xfer_in_s) begin
      out_data_r  <= grant_data_s;
      out_chan_r  <= grant_idx_s;
      out_valid_r <= 1'b1;
      if (mode == 1'b1) begin
        ptr_r <= grant_idx_s;
      end else begin
        ptr_r <= ptr_r;
      end
    end else if (out_ready) begin
      // The word was drained and nothing replaced it. Data and chan are kept.
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_data  = out_data_r;
  assign out_chan  = out_chan_r;
  assign out_valid = out_valid_r;

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr
//   Self-checking bench for stream_mux_rr. The main instance uses WIDTH=8
//   and CHANNELS=8. A second instance with CHANNELS=6 covers select indices
//   that name no channel.
//   The bench holds a table of vectors with the expected in_ready and the
//   granted channel for each one. Every expected transfer pushes an entry to
//   a scoreboard queue. The entry is popped and compared once the output
//   register has loaded.
module tb_stream_mux_rr;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        mode;
  logic [2:0]  sel;
  logic [63:0] in_data;
  logic [7:0]  in_valid;
  logic [7:0]  in_ready;
  logic [7:0]  out_data;
  logic [2:0]  out_chan;
  logic        out_valid;
  logic        out_ready;

  logic        mode6;
  logic [2:0]  sel6;
  logic [47:0] in_data6;
  logic [5:0]  in_valid6;
  logic [5:0]  in_ready6;
  logic [7:0]  out_data6;
  logic [2:0]  out_chan6;
  logic        out_valid6;
  logic        out_ready6;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [2:0] ch;
    logic [7:0] d;
  } exp_t;

  typedef struct {
    logic       m;
    logic [2:0] s;
    logic [7:0] v;
    logic       ordy;
    logic [7:0] rdy;
    logic [2:0] ch;
  } vec_t;

  exp_t       q[$];
  vec_t       tbl[14];
  logic       exp_ov;
  logic [2:0] last_ch;
  logic [7:0] last_d;

  always #5 clk = ~clk;

  stream_mux_rr #(.WIDTH(8), .CHANNELS(8)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  stream_mux_rr #(.WIDTH(8), .CHANNELS(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .mode(mode6), .sel(sel6),
    .in_data(in_data6), .in_valid(in_valid6), .in_ready(in_ready6),
    .out_data(out_data6), .out_chan(out_chan6), .out_valid(out_valid6),
    .out_ready(out_ready6)
  );

  function automatic logic [7:0] data_of(input logic [2:0] ch);
    return in_data[int'(ch)*8 +: 8];
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic clear_model();
    exp_ov  = 1'b0;
    last_ch = 3'd0;
    last_d  = 8'h00;
    q.delete();
  endtask

  // Drive one cycle, check ready before the edge and the output register after it.
  task automatic apply(input logic m, input logic [2:0] s, input logic [7:0] v,
                       input logic ordy, input logic [7:0] exp_rdy,
                       input logic [2:0] exp_ch, input string nm);
    exp_t e;
    @(negedge clk);
    mode = m; sel = s; in_valid = v; out_ready = ordy;
    #1;
    check({nm, ".in_ready"}, 64'(in_ready), 64'(exp_rdy));
    if (exp_rdy != 8'h00) begin
      e.ch = exp_ch;
      e.d  = data_of(exp_ch);
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (exp_rdy != 8'h00) begin
      if (q.size() > 0) begin
        e = q.pop_front();
        last_ch = e.ch;
        last_d  = e.d;
      end
      exp_ov = 1'b1;
    end else if (ordy) begin
      exp_ov = 1'b0;
    end
    check({nm, ".out_valid"}, 64'(out_valid), 64'(exp_ov));
    check({nm, ".out_chan"},  64'(out_chan),  64'(last_ch));
    check({nm, ".out_data"},  64'(out_data),  64'(last_d));
  endtask

  task automatic quick_reset();
    @(negedge clk);
    in_valid = 8'h00;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    clear_model();
  endtask

  initial begin
    in_data   = 64'hF7E6_A5C4_B3A2_9180;
    in_data6  = 48'h5A4B_3C2D_1E0F;
    mode6 = 1'b0; sel6 = 3'd0; in_valid6 = 6'h00; out_ready6 = 1'b1;
    clear_model();

    // Reset values. Inputs are set so that ready would be high if reset did not gate it.
    rst_n = 1'b0; mode = 1'b1; sel = 3'd0; in_valid = 8'hFF; out_ready = 1'b1;
    #2;
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.out_data",  64'(out_data),  64'd0);
    check("rst.out_chan",  64'(out_chan),  64'd0);
    check("rst.in_ready",  64'(in_ready),  64'd0);
    in_valid = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table. ptr starts at 7 after reset.
    tbl[0]  = '{1'b0, 3'd5, 8'hFF, 1'b1, 8'h20, 3'd5}; // fixed sel 5
    tbl[1]  = '{1'b1, 3'd0, 8'hFF, 1'b1, 8'h01, 3'd0}; // rr from ptr 7
    tbl[2]  = '{1'b1, 3'd0, 8'hFF, 1'b1, 8'h02, 3'd1};
    tbl[3]  = '{1'b1, 3'd0, 8'h44, 1'b1, 8'h04, 3'd2}; // sparse ch2/ch6
    tbl[4]  = '{1'b1, 3'd0, 8'h44, 1'b1, 8'h40, 3'd6};
    tbl[5]  = '{1'b1, 3'd0, 8'h44, 1'b1, 8'h04, 3'd2}; // wrap from ptr 6
    tbl[6]  = '{1'b1, 3'd0, 8'h44, 1'b1, 8'h40, 3'd6};
    tbl[7]  = '{1'b1, 3'd0, 8'h00, 1'b1, 8'h00, 3'd0}; // nothing valid, drains
    tbl[8]  = '{1'b0, 3'd3, 8'hF7, 1'b1, 8'h00, 3'd0}; // sel 3 not valid
    tbl[9]  = '{1'b0, 3'd3, 8'h08, 1'b0, 8'h08, 3'd3}; // empty reg loads without out_ready
    tbl[10] = '{1'b1, 3'd0, 8'hFF, 1'b0, 8'h00, 3'd0}; // stall
    tbl[11] = '{1'b1, 3'd0, 8'hFF, 1'b1, 8'h80, 3'd7}; // ptr still 6 after mode 0
    tbl[12] = '{1'b1, 3'd0, 8'h80, 1'b1, 8'h80, 3'd7}; // sole requester re-granted
    tbl[13] = '{1'b0, 3'd0, 8'h01, 1'b1, 8'h01, 3'd0};
    for (int i = 0; i < 14; i++) begin
      apply(tbl[i].m, tbl[i].s, tbl[i].v, tbl[i].ordy, tbl[i].rdy, tbl[i].ch,
            $sformatf("vec%0d", i));
    end

    // Round-robin fairness from reset: channels 0..7 and then 0, 1.
    quick_reset();
    for (int k = 0; k < 10; k++) begin
      apply(1'b1, 3'd0, 8'hFF, 1'b1, 8'(1 << (k % 8)), 3'(k % 8),
            $sformatf("rr%0d", k));
    end

    // Backpressure: three stall cycles hold the word, then ch2 and ch3 follow with no gap.
    for (int k = 0; k < 3; k++) begin
      apply(1'b1, 3'd0, 8'hFF, 1'b0, 8'h00, 3'd0, $sformatf("stall%0d", k));
    end
    apply(1'b1, 3'd0, 8'hFF, 1'b1, 8'h04, 3'd2, "resume0");
    apply(1'b1, 3'd0, 8'hFF, 1'b1, 8'h08, 3'd3, "resume1");
    apply(1'b1, 3'd0, 8'hFF, 1'b0, 8'h00, 3'd0, "stall_pre_rst");

    // Reset asserted mid-stall takes effect with no clock edge.
    rst_n = 1'b0;
    #1;
    check("midrst.out_valid", 64'(out_valid), 64'd0);
    check("midrst.out_data",  64'(out_data),  64'd0);
    check("midrst.out_chan",  64'(out_chan),  64'd0);
    check("midrst.in_ready",  64'(in_ready),  64'd0);
    #1;
    rst_n = 1'b1;
    clear_model();
    // First rising edge after release: channel 0 has priority again.
    apply(1'b1, 3'd0, 8'hFF, 1'b1, 8'h01, 3'd0, "post_rst");

    // CHANNELS=6: sel 7 names no channel. sel 5 is a normal grant.
    @(negedge clk);
    mode6 = 1'b0; sel6 = 3'd7; in_valid6 = 6'h3F; out_ready6 = 1'b1;
    #1;
    check("c6_oor.in_ready", 64'(in_ready6), 64'd0);
    @(posedge clk);
    #1;
    check("c6_oor.out_valid", 64'(out_valid6), 64'd0);
    @(negedge clk);
    sel6 = 3'd5;
    #1;
    check("c6_sel5.in_ready", 64'(in_ready6), 64'h20);
    @(posedge clk);
    #1;
    check("c6_sel5.out_valid", 64'(out_valid6), 64'd1);
    check("c6_sel5.out_chan",  64'(out_chan6),  64'd5);
    check("c6_sel5.out_data",  64'(out_data6),  64'h5A);
    @(negedge clk);
    in_valid6 = 6'h00;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
STREAM_MUX_RR -- requirements
Module: stream_mux_rr

Interface
REQ-001 Parameter WIDTH, default 8, data width of each channel in bits; legal range 1..64.
REQ-002 Parameter CHANNELS, default 8, number of input channels; legal range 2..16.
REQ-003 Localparam SEL_W = max(1, clog2(CHANNELS)) sizes all channel-index ports.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 mode  input  1  0 = fixed select by sel; 1 = round-robin arbitration.
REQ-007 sel  input  SEL_W  channel index used when mode = 0.
REQ-008 in_data  input  CHANNELS*WIDTH  flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-009 in_valid  input  CHANNELS  per-channel valid.
REQ-010 in_ready  output  CHANNELS  per-channel ready.
REQ-011 out_data  output  WIDTH  registered selected data.
REQ-012 out_chan  output  SEL_W  registered index of the channel that supplied out_data.
REQ-013 out_valid  output  1  output holds a word.
REQ-014 out_ready  input  1  downstream accepts the word.

Function
REQ-015 Transfer on channel i: in_valid[i] and in_ready[i] both high at a rising clk edge; transfer on output: out_valid and out_ready both high.
REQ-016 Load enable: load_en = !out_valid || out_ready.
REQ-017 Grant (combinational, at most one channel):
  - mode 0: grant = sel if sel < CHANNELS and in_valid[sel]; sel >= CHANNELS grants nothing.
  - mode 1: first i with in_valid[i] searching ptr+1, ptr+2, ... wrapping modulo CHANNELS, ending at ptr.
REQ-018 in_ready[i] = load_en and (i is granted); all other in_ready bits low; in_ready never high for a channel with in_valid low.
REQ-019 On an input transfer: out_data <= granted channel data, out_chan <= granted index, out_valid <= 1 at the same edge; latency exactly 1 cycle.
REQ-020 Output transfer with no input transfer in the same cycle: out_valid <= 0; out_data and out_chan retain their values.
REQ-021 Simultaneous output and input transfer: new word replaces old in the same edge, out_valid stays 1; full throughput of one word per cycle.
REQ-022 Stall: while out_valid=1 and out_ready=0, out_data, out_chan and out_valid are held stable and all in_ready bits are 0.
REQ-023 Round-robin pointer ptr (SEL_W bits) updates to the granted index only on an input transfer in mode 1; unchanged in mode 0 and on stalls.
REQ-024 Wrap-around: search after ptr = CHANNELS-1 continues at index 0; indices >= CHANNELS never granted.
REQ-025 mode or sel changes take effect in the same cycle's grant; a word already in the output register is unaffected.
REQ-026 No valid inputs: no grant, no load; out_valid falls after any pending output transfer.

Reset
REQ-027 rst_n low asynchronously forces out_valid=0, out_data=0, out_chan=0, ptr=CHANNELS-1 (channel 0 has first round-robin priority).
REQ-028 While rst_n is low, all in_ready bits are 0; reset mid-stall discards the held word.
REQ-029 First input transfer is possible at the first rising edge after rst_n deasserts.

Verification (WIDTH=8, CHANNELS=8)
REQ-030 Fixed mode: mode=0, sel=5, in_valid=8'hFF, ch5=8'hA5, out_ready=1 -> in_ready=8'h20; next cycle out_data=8'hA5, out_chan=5, out_valid=1.
REQ-031 Round-robin fairness: mode=1, all channels valid, out_ready=1 for 10 cycles after reset -> out_chan sequence 0,1,2,3,4,5,6,7,0,1.
REQ-032 Sparse round-robin and wrap: valid only ch2 and ch6, ptr=6 -> grant ch2, then ch6, then ch2.
REQ-033 Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_data/out_chan constant, in_ready=0; out_ready=1 -> next word loaded same edge, no gap, no duplicate.
REQ-034 Out-of-range and reset: mode=0, sel=7 with CHANNELS=6 -> in_ready=0 and out_valid stays 0; rst_n pulsed low mid-stall -> out_valid=0, out_data=0 immediately without a clock edge.
